// File: rtl/slot_machine_multi.sv
// N-reel slot machine: LFSR-driven reels stopped one after another by a spin FSM,
// with jackpot/pair evaluation and a saturating credit balance.
module slot_machine_multi #(
  parameter int                NUM_REELS    = 3,
  parameter int                SYM_W        = 3,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1,
  parameter int                SPIN_CYCLES  = 32,
  parameter int                STOP_GAP     = 8,
  parameter int                CREDIT_W     = 8,
  parameter int                JACKPOT_MULT = 10,
  parameter int                PAIR_MULT    = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         coin_in,
  input  logic                         start,
  input  logic [CREDIT_W-1:0]          bet,
  output logic [NUM_REELS*SYM_W-1:0]   symbols,
  output logic [NUM_REELS-1:0]         reel_stopped,
  output logic                         busy,
  output logic                         reject,
  output logic                         done,
  output logic                         win,
  output logic                         jackpot,
  output logic [CREDIT_W-1:0]          payout,
  output logic [CREDIT_W-1:0]          credits
);

  localparam int LAST  = SPIN_CYCLES + (NUM_REELS - 1) * STOP_GAP;
  localparam int CNT_W = $clog2(LAST + 1);
  localparam int PW    = 2 * CREDIT_W;
  localparam logic [CREDIT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, SPIN, EVAL} state_t;

  state_t                state, state_n;
  logic [LFSR_W-1:0]     lfsr;
  logic [CNT_W-1:0]      cnt, cnt_inc;
  logic [CREDIT_W-1:0]   bet_q;
  logic [SYM_W-1:0]      reel [NUM_REELS];
  logic                  accept, refuse, eval;
  logic                  all_eq, pair;
  logic [CREDIT_W-1:0]   pay_n;

  // Product formed at double width so large bets clamp instead of wrapping.
  function automatic logic [CREDIT_W-1:0] sat_mul(input logic [CREDIT_W-1:0] a, input int m);
    logic [PW-1:0] p;
    p = {{CREDIT_W{1'b0}}, a} * PW'(m);
    return (p > {{CREDIT_W{1'b0}}, CMAX}) ? CMAX : p[CREDIT_W-1:0];
  endfunction

  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b,
                                                  input logic                c);
    logic [CREDIT_W+1:0] s;
    s = {2'b00, a} + {2'b00, b} + {{(CREDIT_W+1){1'b0}}, c};
    return (s > {2'b00, CMAX}) ? CMAX : s[CREDIT_W-1:0];
  endfunction

  assign cnt_inc = cnt + 1'b1;
  assign busy    = (state != IDLE);

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_sym
    assign symbols[g*SYM_W +: SYM_W] = reel[g];
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    refuse  = 1'b0;
    eval    = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (bet != '0 && bet <= credits) begin
          accept  = 1'b1;
          state_n = SPIN;
        end else begin
          refuse  = 1'b1;
        end
      end
      SPIN: if (cnt_inc == CNT_W'(LAST)) state_n = EVAL;
      EVAL: begin
        eval    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (reel[i] != reel[0]) all_eq = 1'b0;
    end
    pair = (reel[1] == reel[0]);
    if (all_eq)    pay_n = sat_mul(bet_q, JACKPOT_MULT);
    else if (pair) pay_n = sat_mul(bet_q, PAIR_MULT);
    else           pay_n = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Stage boundary: all registered datapath and result state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lfsr         <= LFSR_SEED;
      cnt          <= '0;
      bet_q        <= '0;
      credits      <= '0;
      payout       <= '0;
      win          <= 1'b0;
      jackpot      <= 1'b0;
      reel_stopped <= '0;
      reject       <= 1'b0;
      done         <= 1'b0;
      for (int k = 0; k < NUM_REELS; k++) reel[k] <= '0;
    end else begin
      lfsr   <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
      reject <= refuse;
      done   <= eval;
      if (accept) begin
        credits      <= credits - bet + {{(CREDIT_W-1){1'b0}}, coin_in};
        bet_q        <= bet;
        win          <= 1'b0;
        jackpot      <= 1'b0;
        payout       <= '0;
        reel_stopped <= '0;
        cnt          <= '0;
      end else if (eval) begin
        credits <= sat_add(credits, pay_n, coin_in);
        payout  <= pay_n;
        win     <= (pay_n != '0);
        jackpot <= all_eq;
      end else begin
        credits <= sat_add(credits, '0, coin_in);
      end
      // A reel keeps sampling the LFSR up to and including the edge it stops on.
      if (state == SPIN) begin
        cnt <= cnt_inc;
        for (int k = 0; k < NUM_REELS; k++) begin
          if (!reel_stopped[k]) reel[k] <= lfsr[k*SYM_W +: SYM_W];
          if (cnt_inc == CNT_W'(SPIN_CYCLES + k * STOP_GAP)) reel_stopped[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/slot_machine_multi.md
Name: slot_machine_multi

Overview:
- Parametrised successor to the 3-reel slot machine. Supports N reels of configurable symbol width, driven by a free-running Galois LFSR.
- Reels stop one after another under a timed spin FSM. The block evaluates jackpot and pair wins and keeps a saturating credit balance fed by coin insertion, bets and payouts.
- Sits between the front-panel input logic (coin, start, bet switches) and the reel display / credit display drivers.

Parameters:
- NUM_REELS, 3: number of reels, 2..8.
- SYM_W, 3: bits per symbol. Legal only if NUM_REELS*SYM_W <= LFSR_W.
- LFSR_W, 16: LFSR width.
- LFSR_TAPS, 16'hB400: Galois feedback mask.
- LFSR_SEED, 16'hACE1: reset value of the LFSR. Must be nonzero.
- SPIN_CYCLES, 32: cycles from start acceptance to reel 0 stopping. Must be >= 1.
- STOP_GAP, 8: cycles between successive reel stops. Must be >= 1.
- CREDIT_W, 8: credit, bet and payout width.
- JACKPOT_MULT, 10: payout multiplier when all reels are equal.
- PAIR_MULT, 2: payout multiplier when reel 0 equals reel 1 but there is no jackpot.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- coin_in  in  1  one-cycle pulse that adds one credit
- start  in  1  level; request a spin
- bet  in  CREDIT_W  wager, sampled when start is accepted
- symbols  out  NUM_REELS*SYM_W  reel i occupies bits [i*SYM_W +: SYM_W]
- reel_stopped  out  NUM_REELS  bit i set once reel i is final
- busy  out  1  high while in SPIN or EVAL
- reject  out  1  one-cycle pulse when start is refused
- done  out  1  one-cycle pulse when the result is valid
- win  out  1  payout is nonzero
- jackpot  out  1  all reels equal
- payout  out  CREDIT_W  credits awarded on the last spin
- credits  out  CREDIT_W  current balance

Behaviour:
- Reset (reset==0 at a rising edge):
  - All outputs go to 0; state goes to IDLE; the LFSR is loaded with LFSR_SEED.
  - Reset overrides everything, including an active spin. The bet of an interrupted spin is discarded and no done is issued.
- LFSR:
  - Advances every cycle outside reset, in every state.
  - Update: shift right by one; if the old bit 0 was 1, XOR the result with LFSR_TAPS.
- FSM states: IDLE, SPIN, EVAL.
- Start handling in IDLE, when start==1:
  - Accept if bet!=0 and bet<=credits. At that edge (cycle 0):
    - credits <= credits - bet (+1 if coin_in is also high);
    - bet is latched;
    - win, jackpot, payout, reel_stopped are cleared;
    - cycle counter is cleared;
    - state -> SPIN.
  - Otherwise reject=1 for one cycle and state stays IDLE.
  - start held high re-evaluates every IDLE cycle. The bench drives start as a pulse.
- start in SPIN or EVAL: ignored; no reject.
- SPIN:
  - The cycle counter increments each edge.
  - Each non-stopped reel i loads LFSR bits [i*SYM_W +: SYM_W] every edge.
  - Reel k stops at the edge where the counter reaches SPIN_CYCLES + k*STOP_GAP. The value loaded at that edge is final, and reel_stopped[k] is set at the same edge.
  - When the last reel stops, state -> EVAL.
- EVAL (one cycle). At its exit edge:
  - If all reels are equal: jackpot=1, payout = min(bet*JACKPOT_MULT, 2^CREDIT_W-1).
  - Else if reel0==reel1: payout = min(bet*PAIR_MULT, max).
  - Else payout=0.
  - win = (payout != 0).
  - credits <= min(credits + payout + coin_in, max).
  - done=1 for one cycle; state -> IDLE.
- Multiplication is performed at full width (2*CREDIT_W) before saturation.
- Latency: done is high in the cycle after edge SPIN_CYCLES + (NUM_REELS-1)*STOP_GAP + 1, counted from the acceptance edge. With the defaults that is edge 49.
- symbols, win, jackpot and payout hold their values until the next accepted start.
- coin_in:
  - In any state, credits <= min(credits+1, max).
  - Combined with the acceptance or EVAL updates in the same cycle as defined above; never lost.
- Credits never wrap in either direction. Underflow is impossible because acceptance requires bet<=credits.

Test Plan:
- Reset low 2 cycles, then release → all outputs 0. Five coin_in pulses → credits=5.
- credits=5, bet=2, start pulse:
  - credits=3 and busy=1 the next cycle.
  - reel_stopped bits set at edges 32, 40, 48.
  - done pulses once, in the cycle after edge 49; busy=0 afterwards.
- Compare win, jackpot and payout against a model applied to the final symbols. Run 200 spins with a bet of 1 and coins topped up, so that at least one pair win occurs: payout=2 and credits increase by 2.
- bet=0, or bet=6 with credits=5 → reject pulse, credits unchanged, busy stays 0. start during SPIN → ignored, no reject.
- Reset driven low at edge 20 of a spin → all outputs 0 the next cycle, no done. A subsequent spin with the same stimulus gives identical symbols, because the LFSR was reseeded.
- Saturation: CREDIT_W=4, credits=15, coin_in pulse → credits stays 15. coin_in on the acceptance edge with bet=3 → credits=13.
